// File: rtl/bp_update_scheduler_pkg.sv
// Shared definitions for the branch-predictor update scheduler.
// Contents: scheduler state encoding, 2-bit counter constants, default widths
// and the saturating counter step used for read-modify-write PT updates.
package bp_update_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_CAP  = 2'd2,
    ST_WR   = 2'd3
  } sched_state_t;

  localparam logic [1:0] PT_INIT = 2'b01;
  localparam logic [1:0] PT_MAX  = 2'b11;
  localparam logic [1:0] PT_MIN  = 2'b00;

  localparam int unsigned DEF_PT_INDEX_BITS  = 8;
  localparam int unsigned DEF_BTB_INDEX_BITS = 4;
  localparam int unsigned DEF_TAG_BITS       = 26;
  localparam int unsigned DEF_DBITS          = 32;
  localparam int unsigned DEF_BHR_BITS       = 8;
  localparam int unsigned DEF_QDEPTH         = 4;

  function automatic logic [1:0] pt_next(input logic [1:0] cur, input logic taken);
    if (taken) return (cur == PT_MAX) ? PT_MAX : cur + 2'd1;
    else       return (cur == PT_MIN) ? PT_MIN : cur - 2'd1;
  endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO holding resolved-branch updates awaiting a PT/BTB write.
// Ports: clk, reset (async, active-high), i_push/i_wdata (write side),
// i_pop/o_rdata (head is visible combinationally), o_full, o_empty.
// DEPTH must be a power of two, at least 2. Push when full and pop when
// empty are ignored.
module bp_update_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bp_update_scheduler.sv
// Branch-predictor update scheduler: sequences every write into the PT
// (2-bit counters), the BTB tag/target arrays and the BHR.
// Ports:
//   clk, reset                      clock, async active-high reset
//   upd_valid/upd_ready, upd_*      resolved-branch push from execute
//   fe_rd_req                       fetch owns the shared table port
//   init_done                       tables swept, fetch may look up
//   bhr                             branch history
//   pt_re/pt_addr/pt_rdata          PT synchronous read
//   pt_we/pt_wdata                  PT write
//   btb_we/btb_addr/btb_tag/btb_value BTB write
// Optional: define BP_SCHED_STATS_EN to add stat_updates / stat_conflicts.
module bp_update_scheduler
  import bp_update_scheduler_pkg::*;
#(
  parameter int unsigned PT_INDEX_BITS  = DEF_PT_INDEX_BITS,
  parameter int unsigned BTB_INDEX_BITS = DEF_BTB_INDEX_BITS,
  parameter int unsigned TAG_BITS       = DEF_TAG_BITS,
  parameter int unsigned DBITS          = DEF_DBITS,
  parameter int unsigned BHR_BITS       = DEF_BHR_BITS,
  parameter int unsigned QDEPTH         = DEF_QDEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [PT_INDEX_BITS-1:0]  upd_pt_idx,
  input  logic [BTB_INDEX_BITS-1:0] upd_btb_idx,
  input  logic [TAG_BITS-1:0]       upd_tag,
  input  logic [DBITS-1:0]          upd_target,
  input  logic                      upd_taken,
  input  logic                      fe_rd_req,
  output logic                      init_done,
  output logic [BHR_BITS-1:0]       bhr,
  output logic                      pt_re,
  output logic [PT_INDEX_BITS-1:0]  pt_addr,
  input  logic [1:0]                pt_rdata,
  output logic                      pt_we,
  output logic [1:0]                pt_wdata,
  output logic                      btb_we,
  output logic [BTB_INDEX_BITS-1:0] btb_addr,
  output logic [TAG_BITS-1:0]       btb_tag,
  output logic [DBITS-1:0]          btb_value
`ifdef BP_SCHED_STATS_EN
  ,
  output logic [31:0]               stat_updates,
  output logic [31:0]               stat_conflicts
`endif
);

  // FIFO entry layout, LSB first: taken, target, tag, btb_idx, pt_idx
  localparam int unsigned OFF_TGT = 1;
  localparam int unsigned OFF_TAG = OFF_TGT + DBITS;
  localparam int unsigned OFF_BTB = OFF_TAG + TAG_BITS;
  localparam int unsigned OFF_PT  = OFF_BTB + BTB_INDEX_BITS;
  localparam int unsigned EW      = OFF_PT + PT_INDEX_BITS;

  sched_state_t             r_state;
  logic [PT_INDEX_BITS-1:0] r_sweep;
  logic                     r_init_done;
  logic [BHR_BITS-1:0]      r_bhr;
  logic [1:0]               r_cnt;

  logic [EW-1:0]             w_wdata;
  logic [EW-1:0]             w_head;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_head_taken;
  logic [DBITS-1:0]          w_head_tgt;
  logic [TAG_BITS-1:0]       w_head_tag;
  logic [BTB_INDEX_BITS-1:0] w_head_btb;
  logic [PT_INDEX_BITS-1:0]  w_head_pt;

  assign w_wdata      = {upd_pt_idx, upd_btb_idx, upd_tag, upd_target, upd_taken};
  assign w_head_taken = w_head[0];
  assign w_head_tgt   = w_head[OFF_TGT +: DBITS];
  assign w_head_tag   = w_head[OFF_TAG +: TAG_BITS];
  assign w_head_btb   = w_head[OFF_BTB +: BTB_INDEX_BITS];
  assign w_head_pt    = w_head[OFF_PT +: PT_INDEX_BITS];

  assign upd_ready = r_init_done && !w_full;
  assign w_push    = upd_valid && upd_ready;
  assign w_pop     = (r_state == ST_WR) && !fe_rd_req;
  assign init_done = r_init_done;
  assign bhr       = r_bhr;

  bp_update_fifo #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_sweep     <= '0;
      r_init_done <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_sweep <= r_sweep + PT_INDEX_BITS'(1);
          if (r_sweep == '1) begin
            r_state     <= ST_IDLE;
            r_init_done <= 1'b1;
          end
        end
        ST_IDLE: if (!w_empty && !fe_rd_req) r_state <= ST_CAP;
        ST_CAP: begin
          r_cnt   <= pt_next(pt_rdata, w_head_taken);
          r_state <= ST_WR;
        end
        ST_WR:   if (!fe_rd_req) r_state <= ST_IDLE;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_bhr <= '0;
    else if (w_push) r_bhr <= {r_bhr[BHR_BITS-2:0], upd_taken};
  end

  // Reset state is INIT, whose decode would write; gating on reset keeps
  // every enable and bus at 0 while reset is held.
  always_comb begin
    pt_re     = 1'b0;
    pt_we     = 1'b0;
    pt_addr   = '0;
    pt_wdata  = '0;
    btb_we    = 1'b0;
    btb_addr  = '0;
    btb_tag   = '0;
    btb_value = '0;
    if (!reset) begin
      case (r_state)
        ST_INIT: begin
          pt_we    = 1'b1;
          pt_addr  = r_sweep;
          pt_wdata = PT_INIT;
          // BTB is smaller than PT; only the low part of the sweep hits it
          btb_we   = ((r_sweep >> BTB_INDEX_BITS) == '0);
          btb_addr = r_sweep[BTB_INDEX_BITS-1:0];
        end
        ST_IDLE: begin
          if (!w_empty && !fe_rd_req) begin
            pt_re   = 1'b1;
            pt_addr = w_head_pt;
          end
        end
        ST_WR: begin
          if (!fe_rd_req) begin
            pt_we    = 1'b1;
            pt_addr  = w_head_pt;
            pt_wdata = r_cnt;
            if (w_head_taken) begin
              btb_we    = 1'b1;
              btb_addr  = w_head_btb;
              btb_tag   = w_head_tag;
              btb_value = w_head_tgt;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BP_SCHED_STATS_EN
  logic [31:0] r_stat_updates;
  logic [31:0] r_stat_conflicts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_updates   <= '0;
      r_stat_conflicts <= '0;
    end else begin
      if (w_pop) r_stat_updates <= r_stat_updates + 32'd1;
      if (fe_rd_req && (((r_state == ST_IDLE) && !w_empty) || (r_state == ST_WR)))
        r_stat_conflicts <= r_stat_conflicts + 32'd1;
    end
  end

  assign stat_updates   = r_stat_updates;
  assign stat_conflicts = r_stat_conflicts;
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
module tb_bp_update_scheduler;

  logic        clk;
  logic        reset;
  logic        upd_valid;
  logic        upd_ready;
  logic [7:0]  upd_pt_idx;
  logic [3:0]  upd_btb_idx;
  logic [25:0] upd_tag;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        fe_rd_req;
  logic        init_done;
  logic [7:0]  bhr;
  logic        pt_re;
  logic [7:0]  pt_addr;
  logic [1:0]  pt_rdata;
  logic        pt_we;
  logic [1:0]  pt_wdata;
  logic        btb_we;
  logic [3:0]  btb_addr;
  logic [25:0] btb_tag;
  logic [31:0] btb_value;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  pt;
    logic [3:0]  btb;
    logic [25:0] tag;
    logic [31:0] tgt;
    logic        taken;
  } upd_t;

  upd_t       expq[$];
  logic [1:0] ref_pt [256];
  logic [7:0] ref_bhr;

  // PT RAM environment: synchronous read, optional forced read data
  logic [1:0] ram [256];
  logic [1:0] ram_q;
  logic       force_rd;
  logic [1:0] force_val;

  always @(posedge clk) begin
    if (pt_re) ram_q <= ram[pt_addr];
    if (pt_we) ram[pt_addr] <= pt_wdata;
  end
  assign pt_rdata = force_rd ? force_val : ram_q;

  bp_update_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_pt_idx (upd_pt_idx),
    .upd_btb_idx(upd_btb_idx),
    .upd_tag    (upd_tag),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .fe_rd_req  (fe_rd_req),
    .init_done  (init_done),
    .bhr        (bhr),
    .pt_re      (pt_re),
    .pt_addr    (pt_addr),
    .pt_rdata   (pt_rdata),
    .pt_we      (pt_we),
    .pt_wdata   (pt_wdata),
    .btb_we     (btb_we),
    .btb_addr   (btb_addr),
    .btb_tag    (btb_tag),
    .btb_value  (btb_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 2-bit saturating counter, computed as clamped integer arithmetic
  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
    int v;
    v = int'(c) + (taken ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  task automatic test_reset();
    logic exp_btb;
    reset = 1'b1; upd_valid = 1'b0; fe_rd_req = 1'b0; force_rd = 1'b0; force_val = 2'b00;
    upd_pt_idx = '0; upd_btb_idx = '0; upd_tag = '0; upd_target = '0; upd_taken = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({pt_re, pt_we, btb_we, init_done, upd_ready} !== 5'b0 || pt_addr !== 8'h0 ||
        pt_wdata !== 2'b0 || btb_addr !== 4'h0 || btb_tag !== 26'h0 || btb_value !== 32'h0 || bhr !== 8'h0) begin
      failures++;
      $display("FAIL reset_values re=%b we=%b btb_we=%b init_done=%b ready=%b addr=%h bhr=%h required all 0",
               pt_re, pt_we, btb_we, init_done, upd_ready, pt_addr, bhr);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      fe_rd_req = 1'($urandom_range(0, 1));
      #1;
      exp_btb = (i < 16);
      checks++;
      if (init_done !== 1'b0 || pt_we !== 1'b1 || pt_re !== 1'b0 || pt_addr !== 8'(i) || pt_wdata !== 2'b01) begin
        failures++;
        $display("FAIL sweep_pt i=%0d init_done=%b we=%b re=%b addr=%0d wdata=%b required 0/1/0/%0d/01",
                 i, init_done, pt_we, pt_re, pt_addr, pt_wdata, i);
      end
      checks++;
      if (btb_we !== exp_btb || (exp_btb && (btb_addr !== 4'(i) || btb_tag !== 26'h0 || btb_value !== 32'h0))) begin
        failures++;
        $display("FAIL sweep_btb i=%0d btb_we=%b addr=%0d tag=%h value=%h required we=%b addr=%0d zeros",
                 i, btb_we, btb_addr, btb_tag, btb_value, exp_btb, i % 16);
      end
      @(negedge clk);
    end
    fe_rd_req = 1'b0;
    #1;
    checks++;
    if (init_done !== 1'b1 || pt_we !== 1'b0 || btb_we !== 1'b0 || upd_ready !== 1'b1) begin
      failures++;
      $display("FAIL init_done_rise init_done=%b we=%b btb_we=%b ready=%b required 1/0/0/1",
               init_done, pt_we, btb_we, upd_ready);
    end
    for (int i = 0; i < 256; i++) ref_pt[i] = 2'b01;
    ref_bhr = 8'h00;
    expq.delete();
  endtask

  task automatic test_back_to_back();
    logic [4:0] pat;
    upd_t       e;
    logic [1:0] exp_d;
    int         n;
    pat = 5'b11101;
    @(negedge clk);
    fe_rd_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      upd_valid = 1'b1; upd_pt_idx = 8'(40 + k); upd_btb_idx = 4'(8 + k);
      upd_tag = 26'($urandom); upd_target = $urandom; upd_taken = pat[k];
      #1;
      checks++;
      if (upd_ready !== (k < 4)) begin
        failures++;
        $display("FAIL b2b_ready push=%0d ready=%b required %b", k, upd_ready, (k < 4));
      end
      checks++;
      if (pt_re || pt_we || btb_we) begin
        failures++;
        $display("FAIL b2b_fetch_block push=%0d re=%b we=%b btb_we=%b required 0", k, pt_re, pt_we, btb_we);
      end
      if (upd_ready) begin
        expq.push_back('{upd_pt_idx, upd_btb_idx, upd_tag, upd_target, upd_taken});
        ref_bhr = {ref_bhr[6:0], upd_taken};
      end
      @(negedge clk);
    end
    upd_valid = 1'b0;
    #1;
    checks++;
    if (bhr !== 8'h0B || upd_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_bhr bhr=%h ready=%b required 0b/0", bhr, upd_ready);
    end
    fe_rd_req = 1'b0;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk); #1;
      if (pt_we) begin
        e = expq.pop_front();
        exp_d = sat_step(ref_pt[e.pt], e.taken);
        checks++;
        if (pt_addr !== e.pt || pt_wdata !== exp_d || btb_we !== e.taken ||
            (e.taken && (btb_addr !== e.btb || btb_tag !== e.tag || btb_value !== e.tgt))) begin
          failures++;
          $display("FAIL b2b_drain n=%0d addr=%0d wdata=%b btb_we=%b btb_addr=%0d value=%h required %0d/%b/%b/%0d/%h",
                   n, pt_addr, pt_wdata, btb_we, btb_addr, btb_value, e.pt, exp_d, e.taken, e.btb, e.tgt);
        end
        ref_pt[e.pt] = exp_d;
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL b2b_drain_timeout writes=%0d required 4", n);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    upd_valid = 1'b1; upd_pt_idx = 8'd5; upd_btb_idx = 4'd3; upd_tag = 26'h155AA;
    upd_target = 32'h0000_1000; upd_taken = 1'b1;
    #1;
    checks++;
    if (upd_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready ready=%b required 1", upd_ready);
    end
    ref_bhr = {ref_bhr[6:0], 1'b1};
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    checks++;
    if (pt_re !== 1'b1 || pt_addr !== 8'd5 || pt_we !== 1'b0 || bhr !== ref_bhr) begin
      failures++;
      $display("FAIL single_read re=%b addr=%0d we=%b bhr=%h required 1/5/0/%h", pt_re, pt_addr, pt_we, bhr, ref_bhr);
    end
    @(negedge clk); #1;
    checks++;
    if (pt_re || pt_we || btb_we) begin
      failures++;
      $display("FAIL single_cap re=%b we=%b btb_we=%b required 0", pt_re, pt_we, btb_we);
    end
    @(negedge clk); #1;
    checks++;
    if (pt_we !== 1'b1 || pt_addr !== 8'd5 || pt_wdata !== 2'b10 || btb_we !== 1'b1 ||
        btb_addr !== 4'd3 || btb_tag !== 26'h155AA || btb_value !== 32'h0000_1000) begin
      failures++;
      $display("FAIL single_write we=%b addr=%0d wdata=%b btb_we=%b btb_addr=%0d tag=%h value=%h required 1/5/10/1/3/155aa/1000",
               pt_we, pt_addr, pt_wdata, btb_we, btb_addr, btb_tag, btb_value);
    end
    ref_pt[5] = 2'b10;
    @(negedge clk); #1;
    checks++;
    if (pt_re || pt_we || btb_we) begin
      failures++;
      $display("FAIL single_after re=%b we=%b btb_we=%b required 0", pt_re, pt_we, btb_we);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] idx;
    logic [1:0] fv;
    logic       tk;
    logic       seen_we;
    logic       seen_btb;
    logic [1:0] got;
    for (int s = 0; s < 2; s++) begin
      idx = (s == 0) ? 8'd9 : 8'd10;
      fv  = (s == 0) ? 2'b11 : 2'b00;
      tk  = (s == 0);
      @(negedge clk);
      force_rd = 1'b1; force_val = fv;
      upd_valid = 1'b1; upd_pt_idx = idx; upd_btb_idx = 4'(s + 1);
      upd_tag = 26'($urandom); upd_target = $urandom; upd_taken = tk;
      ref_bhr = {ref_bhr[6:0], tk};
      @(negedge clk);
      upd_valid = 1'b0;
      seen_we = 1'b0; seen_btb = 1'b0; got = 2'bxx;
      for (int c = 0; c < 10 && !seen_we; c++) begin
        #1;
        if (btb_we) seen_btb = 1'b1;
        if (pt_we) begin seen_we = 1'b1; got = pt_wdata; end
        @(negedge clk);
      end
      checks++;
      if (!seen_we || got !== fv) begin
        failures++;
        $display("FAIL saturate_data case=%0d seen=%b wdata=%b required %b", s, seen_we, got, fv);
      end
      checks++;
      if (seen_btb !== tk) begin
        failures++;
        $display("FAIL saturate_btb case=%0d btb_we_seen=%b required %b", s, seen_btb, tk);
      end
      ref_pt[idx] = fv;
      force_rd = 1'b0;
    end
  endtask

  task automatic test_stall();
    logic [31:0] tgt;
    tgt = $urandom;
    @(negedge clk);
    upd_valid = 1'b1; upd_pt_idx = 8'd20; upd_btb_idx = 4'd7; upd_tag = 26'h3ABCDE;
    upd_target = tgt; upd_taken = 1'b1;
    ref_bhr = {ref_bhr[6:0], 1'b1};
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    checks++;
    if (pt_re !== 1'b1 || pt_addr !== 8'd20) begin
      failures++;
      $display("FAIL stall_read re=%b addr=%0d required 1/20", pt_re, pt_addr);
    end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      fe_rd_req = 1'b1;
      #1;
      checks++;
      if (pt_re || pt_we || btb_we) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d re=%b we=%b btb_we=%b required 0", k, pt_re, pt_we, btb_we);
      end
    end
    @(negedge clk);
    fe_rd_req = 1'b0;
    #1;
    checks++;
    if (pt_we !== 1'b1 || pt_addr !== 8'd20 || pt_wdata !== 2'b10 || btb_we !== 1'b1 ||
        btb_addr !== 4'd7 || btb_tag !== 26'h3ABCDE || btb_value !== tgt) begin
      failures++;
      $display("FAIL stall_write we=%b addr=%0d wdata=%b btb_we=%b btb_addr=%0d value=%h required 1/20/10/1/7/%h",
               pt_we, pt_addr, pt_wdata, btb_we, btb_addr, btb_value, tgt);
    end
    ref_pt[20] = 2'b10;
    @(negedge clk); #1;
    checks++;
    if (pt_re || pt_we || btb_we || bhr !== ref_bhr) begin
      failures++;
      $display("FAIL stall_after re=%b we=%b btb_we=%b bhr=%h required 0/0/0/%h", pt_re, pt_we, btb_we, bhr, ref_bhr);
    end
  endtask

  task automatic test_random();
    int         accepted;
    int         cyc;
    upd_t       e;
    logic [1:0] exp_d;
    accepted = 0;
    cyc = 0;
    @(negedge clk);
    while ((accepted < 60 || expq.size() != 0) && cyc < 3000) begin
      fe_rd_req   = ($urandom_range(0, 3) == 0);
      upd_valid   = (accepted < 60) && ($urandom_range(0, 1) == 1);
      upd_pt_idx  = 8'($urandom_range(0, 7));
      upd_btb_idx = 4'($urandom);
      upd_tag     = 26'($urandom);
      upd_target  = $urandom;
      upd_taken   = 1'($urandom);
      #1;
      checks++;
      if (bhr !== ref_bhr) begin
        failures++;
        $display("FAIL rand_bhr cycle=%0d bhr=%h required %h", cyc, bhr, ref_bhr);
      end
      if (fe_rd_req && (pt_re || pt_we || btb_we)) begin
        checks++;
        failures++;
        $display("FAIL rand_fetch_priority cycle=%0d re=%b we=%b btb_we=%b required 0", cyc, pt_re, pt_we, btb_we);
      end
      if (pt_re) begin
        checks++;
        if (expq.size() == 0 || pt_addr !== expq[0].pt) begin
          failures++;
          $display("FAIL rand_read cycle=%0d addr=%0d pending=%0d required head index", cyc, pt_addr, expq.size());
        end
      end
      if (pt_we) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL rand_spurious_write cycle=%0d addr=%0d required no write", cyc, pt_addr);
        end else begin
          e = expq.pop_front();
          exp_d = sat_step(ref_pt[e.pt], e.taken);
          if (pt_addr !== e.pt || pt_wdata !== exp_d || btb_we !== e.taken ||
              (e.taken && (btb_addr !== e.btb || btb_tag !== e.tag || btb_value !== e.tgt))) begin
            failures++;
            $display("FAIL rand_write cycle=%0d addr=%0d wdata=%b btb_we=%b btb_addr=%0d value=%h required %0d/%b/%b/%0d/%h",
                     cyc, pt_addr, pt_wdata, btb_we, btb_addr, btb_value, e.pt, exp_d, e.taken, e.btb, e.tgt);
          end
          ref_pt[e.pt] = exp_d;
        end
      end else if (btb_we) begin
        checks++;
        failures++;
        $display("FAIL rand_btb_alone cycle=%0d btb_we=1 required 0 without pt_we", cyc);
      end
      if (upd_valid && upd_ready) begin
        expq.push_back('{upd_pt_idx, upd_btb_idx, upd_tag, upd_target, upd_taken});
        ref_bhr = {ref_bhr[6:0], upd_taken};
        accepted++;
      end
      @(negedge clk);
      cyc++;
    end
    upd_valid = 1'b0;
    fe_rd_req = 1'b0;
    checks++;
    if (accepted != 60 || expq.size() != 0) begin
      failures++;
      $display("FAIL rand_timeout accepted=%0d pending=%0d required 60/0", accepted, expq.size());
    end
  endtask

  task automatic test_reset_mid();
    int init_cycles;
    @(negedge clk);
    fe_rd_req = 1'b0;
    upd_valid = 1'b1; upd_pt_idx = 8'd50; upd_btb_idx = 4'd1; upd_tag = 26'h1; upd_target = 32'h50; upd_taken = 1'b1;
    @(negedge clk);
    upd_pt_idx = 8'd51; upd_taken = 1'b0;
    @(negedge clk);
    upd_valid = 1'b0;
    @(negedge clk);
    fe_rd_req = 1'b1;
    #1;
    checks++;
    if (pt_we || btb_we || pt_re) begin
      failures++;
      $display("FAIL midreset_wr_stall re=%b we=%b btb_we=%b required 0", pt_re, pt_we, btb_we);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (pt_re || pt_we || btb_we || init_done || upd_ready || bhr !== 8'h00) begin
      failures++;
      $display("FAIL midreset_drop re=%b we=%b btb_we=%b init_done=%b ready=%b bhr=%h required all 0",
               pt_re, pt_we, btb_we, init_done, upd_ready, bhr);
    end
    @(negedge clk);
    reset = 1'b0;
    fe_rd_req = 1'b0;
    #1;
    checks++;
    if (pt_we !== 1'b1 || pt_addr !== 8'd0 || btb_we !== 1'b1 || btb_addr !== 4'd0) begin
      failures++;
      $display("FAIL midreset_restart we=%b addr=%0d btb_we=%b btb_addr=%0d required 1/0/1/0",
               pt_we, pt_addr, btb_we, btb_addr);
    end
    init_cycles = 0;
    while (init_done !== 1'b1 && init_cycles < 400) begin
      init_cycles++;
      @(negedge clk); #1;
    end
    checks++;
    if (init_cycles != 256) begin
      failures++;
      $display("FAIL midreset_sweep_len cycles=%0d required 256", init_cycles);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (pt_re || pt_we || btb_we || upd_ready !== 1'b1) begin
        failures++;
        $display("FAIL midreset_fifo_empty cycle=%0d re=%b we=%b btb_we=%b ready=%b required 0/0/0/1",
                 k, pt_re, pt_we, btb_we, upd_ready);
      end
      @(negedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    upd_valid = 1'b0;
    fe_rd_req = 1'b0;
    force_rd = 1'b0;
    force_val = 2'b00;
    test_reset();
    test_back_to_back();
    test_single();
    test_saturation();
    test_stall();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
- Sequences all writes into the branch-predictor state: the pattern table (PT) of 2-bit counters, the BTB tag/target arrays, and the branch history register (BHR).
- The execute stage pushes resolved-branch updates into a small FIFO. The block drains them as read-modify-write PT updates plus BTB writes.
- The table port is single and shared with fetch. Fetch lookups have strict priority.
- After reset, the block sweeps both tables to known values before fetch may use them.

Parameters:
- PT_INDEX_BITS, 8, PT index width; PT has 2^PT_INDEX_BITS entries.
- BTB_INDEX_BITS, 4, BTB index width.
- TAG_BITS, 26, BTB tag width.
- DBITS, 32, target address width.
- BHR_BITS, 8, history register width.
- QDEPTH, 4, update FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- upd_valid  in  1  execute stage offers a resolved branch/jump
- upd_ready  out  1  FIFO can accept; a push occurs when upd_valid && upd_ready
- upd_pt_idx  in  PT_INDEX_BITS  PT index used at fetch
- upd_btb_idx  in  BTB_INDEX_BITS  BTB index
- upd_tag  in  TAG_BITS  tag for the BTB entry
- upd_target  in  DBITS  resolved target
- upd_taken  in  1  actual direction
- fe_rd_req  in  1  fetch is using the table port this cycle
- init_done  out  1  tables initialised; fetch may look up
- bhr  out  BHR_BITS  current history
- pt_re  out  1  PT read enable (synchronous read, data next cycle)
- pt_addr  out  PT_INDEX_BITS  PT read/write index
- pt_rdata  in  2  PT read data
- pt_we  out  1  PT write enable
- pt_wdata  out  2  PT write data
- btb_we  out  1  BTB write enable
- btb_addr  out  BTB_INDEX_BITS  BTB write index
- btb_tag  out  TAG_BITS  BTB tag write data
- btb_value  out  DBITS  BTB target write data

Behaviour:
- Reset values:
  - state INIT, sweep counter 0, FIFO empty, bhr 0.
  - init_done 0, upd_ready 0.
  - All enables 0; address and data outputs 0.
- INIT state:
  - Each cycle writes index i: pt_we=1 with pt_wdata=2'b01 (weakly not-taken); btb_we=1 with tag 0 and value 0, only when i < 2^BTB_INDEX_BITS.
  - fe_rd_req is ignored. Sweep runs 2^PT_INDEX_BITS cycles, then state goes to IDLE.
  - init_done rises on the first IDLE cycle and stays 1 until reset.
- upd_ready = init_done && !full. There is no same-cycle pass-through when full.
- On each push:
  - bhr <= {bhr[BHR_BITS-2:0], upd_taken} on the same edge.
  - The FIFO stores {pt_idx, btb_idx, tag, target, taken}.
- IDLE: if FIFO is non-empty and !fe_rd_req, assert pt_re with pt_addr = head pt_idx and move to CAP. Otherwise stay in IDLE with all enables 0.
- CAP (one cycle): register the new counter value:
  - taken: pt_rdata==3 ? 3 : pt_rdata+1
  - not taken: pt_rdata==0 ? 0 : pt_rdata-1
  - Then move to WR. fe_rd_req has no effect in CAP.
- WR:
  - If fe_rd_req: stall in WR with all enables 0 and registered data held.
  - Else:
    - Assert pt_we with pt_addr = head index and the registered counter.
    - If the head entry is taken, also assert btb_we with head btb_idx/tag/target. Not-taken updates leave the BTB untouched.
    - Pop the FIFO and return to IDLE.
- Latency: with no conflicts, a push on edge E0 gives pt_re in the cycle after E0, and pt_we/btb_we two cycles later.
- Updates are serialised. Back-to-back updates to the same PT index see each other's results, because the next read is issued only after the previous write edge.
- Push and pop on the same edge: the occupancy count is unchanged.
- Fetch never sees pt_re, pt_we or btb_we asserted in a cycle where fe_rd_req=1 after init_done.
- Reset mid-operation: all state is discarded immediately, and INIT restarts from index 0.

Optional Feature:
- Macro BP_SCHED_STATS_EN.
- When defined: adds outputs stat_updates (32b, counts pops) and stat_conflicts (32b, counts cycles where fe_rd_req blocked IDLE-with-work or WR). Both counters reset to 0 and wrap modulo 2^32.
- When undefined: the ports are absent and there is no extra logic.

Decomposition:
- Shared package: state encoding (INIT, IDLE, CAP, WR), counter constants (PT_INIT=2'b01, PT_MAX=2'b11), and the default widths.
- One natural sub-module: bp_update_fifo, a synchronous FIFO with full/empty flags and QDEPTH entries, instantiated once.

Test Plan:
- Reset, then idle: init_done=0 for exactly 256 cycles; PT writes 0..255 with data 01; BTB writes 0..15 with zeros; then init_done=1.
- One taken update to pt_idx 5 (pt_rdata=01), target 0x1000, btb_idx 3: pt_we writes 10 to index 5 and btb_we writes 0x1000 to index 3, two cycles after pt_re.
- Saturation, fixed pt_rdata=3 taken then pt_rdata=0 not-taken: pt_wdata=3 and 0 respectively; the not-taken update produces no btb_we.
- fe_rd_req held high for 5 cycles while in WR: no enables during those cycles; the write occurs in the first cycle fe_rd_req=0, with unchanged data.
- Push 5 updates back-to-back with QDEPTH=4 and fe_rd_req=1: upd_ready drops after 4; bhr shifts only on accepted pushes (taken pattern 1,0,1,1 → bhr=8'h0B).
- Assert reset during WR: all enables drop immediately; the FIFO empties and the INIT sweep restarts at index 0.
